pe2ddr: RTL and testbench
=========================

Name: pe2ddr

Overview:
Write-back engine: the opposite direction of the DDR-to-PE loaders. Drains per-PE result buffers (one PE at a time, in ascending mask order) into DDR over a write address channel and a write data channel, both valid/ready. Started by the layer controller with a transfer config. Signals done when the last data beat has handshaken and all addresses have been accepted.

Parameters:
BUF_DEPTH, 256, words per PE result buffer
PE_NUM, 32, number of PEs / mask width
ADDR_W, bw(BUF_DEPTH), buffer address width
FIFO_DEPTH, 4, read-data skid FIFO depth (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-low
start  in  1  one-cycle pulse, accepted only in IDLE
done  out  1  one-cycle pulse at completion
conf_st_addr  in  DDR_ADDR_W  DDR address of first burst
conf_step  in  DDR_ADDR_W  address increment between PE bursts
conf_word_num  in  BURST_W  words per PE (0 encodes BUF_DEPTH)
conf_mask  in  PE_NUM  PEs to drain
rbuf_rd_addr  out  ADDR_W  result buffer read address
rbuf_rd_en  out  PE_NUM  one-hot read enable
rbuf_rd_data  in  DDR_W  muxed read data, valid 1 cycle after rd_en
ddr_addr  out  DDR_ADDR_W  write burst address
ddr_size  out  BURST_W  write burst length
ddr_addr_valid  out  1  address valid
ddr_addr_ready  in  1  address ready
ddr_data  out  DDR_W  write data
ddr_last  out  1  last beat of burst
ddr_valid  out  1  data valid
ddr_ready  in  1  data ready

Behaviour:
- Reset (rst==0 at clk edge): all outputs 0, FSM IDLE, FIFO empty, counters 0. Mid-transfer reset aborts immediately; no done.
- Config latched on accepted start; inputs ignored afterwards. start outside IDLE ignored.
- FSM: IDLE -> SCAN on start. SCAN: find lowest set bit of remaining mask; none -> DRAIN; else latch pe_idx, clear bit, -> READ. READ: issue reads word 0..N-1; after word N-1 issued -> SCAN. DRAIN: wait until FIFO empty, no read in flight, and address queue empty -> DONE. DONE: pulse done 1 cycle -> IDLE.
- Empty mask: start -> done exactly 3 cycles later; no addresses, no data.
- Read issue: rbuf_rd_en[pe_idx]=1 only when fifo_count + inflight < FIFO_DEPTH (credit rule); read data pushed to FIFO next cycle. No FIFO overflow under any ddr_ready pattern.
- Data channel: ddr_valid = FIFO non-empty; pop on valid&&ready. ddr_last=1 on beat N-1 of each PE burst (tracked by a beat counter per burst, not the read counter). Data/last stable while valid&&!ready.
- Address channel: one burst per selected PE, pushed when that PE enters READ; addr = st_addr + k*step (k = burst ordinal, modulo 2^DDR_ADDR_W wrap), size = N. Address queue depth 2; SCAN stalls if full. Addresses may lead data; data never waits on address acceptance except via this stall.
- Throughput: 1 beat/cycle sustained with ddr_ready held high; read latency adds 2 cycles start-of-burst bubble max.
- N=0 -> BUF_DEPTH words, rd_addr wraps 255->0 never occurs within a burst.

Optional Feature:
PE2DDR_RELU_EN: when defined, each DATA_W signed lane of the popped word is clamped to 0 if negative before ddr_data (combinational, no added latency). When undefined, data passes unmodified.

Decomposition:
- GLOBAL_PARAM supplies DDR_W, DDR_ADDR_W, BURST_W, DATA_W, BATCH, bw(); add pe2ddr_state_t enum there.
- Sub-module pe2ddr_fifo: synchronous FIFO with count output, used for read data (FIFO_DEPTH) and address queue (depth 2).

Test Plan:
- mask=32'h1, N=4, st_addr=0x1000, ready high -> one address (0x1000,4); 4 beats, last on beat 3; done once.
- mask=32'h8000_0005, N=2, step=0x40 -> PEs 0,2,31 in order; addresses 0x1000,0x1040,0x1080; 6 beats.
- ddr_ready random 30% duty, N=16, 3 PEs -> data order exact, no drop/dup, FIFO never exceeds 4.
- mask=0 -> done 3 cycles after start; valids never asserted.
- rst low mid-burst (beat 5 of 16) -> next cycle all outputs 0; new start runs cleanly.
- PE2DDR_RELU_EN defined, lane value -3 -> output lane 0; undefined -> -3 passes.

Source files
------------

// File: rtl/pe2ddr_pkg.sv
// Shared widths, FSM state encoding and helpers for the pe2ddr write-back engine.
// Optional ReLU clamp on output lanes is enabled with the PE2DDR_RELU_EN macro.
package pe2ddr_pkg;

    function automatic int bw(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

    localparam int DATA_W     = 16;
    localparam int BATCH      = 4;
    localparam int DDR_W      = DATA_W * BATCH;
    localparam int DDR_ADDR_W = 32;
    localparam int BURST_W    = bw(256);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } pe2ddr_state_t;

    typedef struct packed {
        logic [DDR_ADDR_W-1:0] addr;
        logic [BURST_W-1:0]    size;
    } burst_cmd_t;

endpackage

// File: rtl/pe2ddr_if.sv
// DDR write address + write data channels (valid/ready) driven by pe2ddr.
interface pe2ddr_if;
    import pe2ddr_pkg::*;

    logic [DDR_ADDR_W-1:0] addr;
    logic [BURST_W-1:0]    size;
    logic                  addr_valid;
    logic                  addr_ready;
    logic [DDR_W-1:0]      data;
    logic                  last;
    logic                  valid;
    logic                  ready;

    modport master (
        output addr, size, addr_valid, data, last, valid,
        input  addr_ready, ready
    );

    modport slave (
        input  addr, size, addr_valid, data, last, valid,
        output addr_ready, ready
    );
endinterface

// File: rtl/pe2ddr_fifo.sv
// Small synchronous FIFO with first-word fall-through head and occupancy count.
module pe2ddr_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);
    localparam int PTR_W = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_reg;
    assign pop_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (do_push && !do_pop)
                count_reg <= count_reg + CNT_W'(1);
            else if (do_pop && !do_push)
                count_reg <= count_reg - CNT_W'(1);
        end
    end

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end
endmodule

// File: rtl/pe2ddr.sv
// Write-back engine: drains masked PE result buffers to DDR in ascending PE order.
// Define PE2DDR_RELU_EN to clamp negative output lanes to zero.
module pe2ddr
    import pe2ddr_pkg::*;
#(
    parameter int BUF_DEPTH  = 256,
    parameter int PE_NUM     = 32,
    parameter int ADDR_W     = bw(BUF_DEPTH),
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  done,
    input  logic [DDR_ADDR_W-1:0] conf_st_addr,
    input  logic [DDR_ADDR_W-1:0] conf_step,
    input  logic [BURST_W-1:0]    conf_word_num,
    input  logic [PE_NUM-1:0]     conf_mask,
    output logic [ADDR_W-1:0]     rbuf_rd_addr,
    output logic [PE_NUM-1:0]     rbuf_rd_en,
    input  logic [DDR_W-1:0]      rbuf_rd_data,
    pe2ddr_if.master              ddr
);
    localparam int PE_IDX_W   = bw(PE_NUM);
    localparam int DATA_CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ADDR_CNT_W = 2;

    localparam logic [2:0] S_IDLE  = 3'(ST_IDLE);
    localparam logic [2:0] S_SCAN  = 3'(ST_SCAN);
    localparam logic [2:0] S_READ  = 3'(ST_READ);
    localparam logic [2:0] S_DRAIN = 3'(ST_DRAIN);
    localparam logic [2:0] S_DONE  = 3'(ST_DONE);

    logic [2:0]            state_reg, state_next;
    logic [PE_NUM-1:0]     mask_reg;
    logic [DDR_ADDR_W-1:0] burst_addr_reg;
    logic [DDR_ADDR_W-1:0] step_reg;
    logic [BURST_W-1:0]    word_num_reg;
    logic [PE_IDX_W-1:0]   pe_idx_reg;
    logic [ADDR_W-1:0]     rd_cnt_reg;
    logic [ADDR_W-1:0]     beat_cnt_reg;
    logic                  rd_inflight_reg;

    logic [PE_IDX_W-1:0]   low_idx;
    logic [ADDR_W-1:0]     last_word;
    logic                  scan_take;
    logic                  rd_fire;
    logic                  rd_last;
    logic                  beat_last;
    logic                  drain_ok;

    logic [DDR_W-1:0]      data_head;
    logic [DATA_CNT_W-1:0] data_count;
    logic                  data_empty;
    logic                  data_pop;
    logic [DDR_W-1:0]      head_gated;
    logic [DDR_W-1:0]      out_data;

    burst_cmd_t            addr_push_cmd;
    burst_cmd_t            addr_head;
    logic [ADDR_CNT_W-1:0] addr_count;
    logic                  addr_empty;
    logic                  addr_full;

    // Word count 0 means a full buffer; the wrap of N-1 yields BUF_DEPTH-1.
    assign last_word = ADDR_W'(word_num_reg - BURST_W'(1));

    always_comb begin
        low_idx = '0;
        for (int i = PE_NUM - 1; i >= 0; i--) begin
            if (mask_reg[i]) low_idx = PE_IDX_W'(i);
        end
    end

    assign addr_full = (addr_count == ADDR_CNT_W'(2));
    assign scan_take = (state_reg == S_SCAN) && (|mask_reg) && !addr_full;
    // Credit: never issue a read the FIFO could not absorb even if nothing pops.
    assign rd_fire   = (state_reg == S_READ)
                    && ((int'(data_count) + int'(rd_inflight_reg)) < FIFO_DEPTH);
    assign rd_last   = (rd_cnt_reg == last_word);
    assign beat_last = (beat_cnt_reg == last_word);
    assign drain_ok  = data_empty && !rd_inflight_reg && addr_empty;
    assign data_pop  = ddr.valid && ddr.ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_SCAN;
            S_SCAN:  begin
                if (!(|mask_reg))  state_next = S_DRAIN;
                else if (!addr_full) state_next = S_READ;
            end
            S_READ:  if (rd_fire && rd_last) state_next = S_SCAN;
            S_DRAIN: if (drain_ok) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg       <= S_IDLE;
            mask_reg        <= '0;
            burst_addr_reg  <= '0;
            step_reg        <= '0;
            word_num_reg    <= '0;
            pe_idx_reg      <= '0;
            rd_cnt_reg      <= '0;
            beat_cnt_reg    <= '0;
            rd_inflight_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            rd_inflight_reg <= rd_fire;
            if (state_reg == S_IDLE && start) begin
                mask_reg       <= conf_mask;
                burst_addr_reg <= conf_st_addr;
                step_reg       <= conf_step;
                word_num_reg   <= conf_word_num;
                beat_cnt_reg   <= '0;
            end
            if (scan_take) begin
                pe_idx_reg     <= low_idx;
                mask_reg       <= mask_reg & ~(PE_NUM'(1) << low_idx);
                burst_addr_reg <= burst_addr_reg + step_reg;
                rd_cnt_reg     <= '0;
            end
            if (rd_fire) rd_cnt_reg <= rd_cnt_reg + ADDR_W'(1);
            if (data_pop) beat_cnt_reg <= beat_last ? '0 : beat_cnt_reg + ADDR_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < PE_NUM; gi++) begin : g_rd_en
            assign rbuf_rd_en[gi] = rd_fire && (pe_idx_reg == PE_IDX_W'(gi));
        end
    endgenerate

    assign rbuf_rd_addr = rd_fire ? rd_cnt_reg : '0;

    pe2ddr_fifo #(
        .WIDTH (DDR_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (DATA_CNT_W)
    ) u_data_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_inflight_reg),
        .push_data (rbuf_rd_data),
        .pop       (data_pop),
        .pop_data  (data_head),
        .count     (data_count),
        .empty     (data_empty)
    );

    assign addr_push_cmd = '{addr: burst_addr_reg, size: word_num_reg};

    pe2ddr_fifo #(
        .WIDTH ($bits(burst_cmd_t)),
        .DEPTH (2),
        .CNT_W (ADDR_CNT_W)
    ) u_addr_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (scan_take),
        .push_data (addr_push_cmd),
        .pop       (ddr.addr_valid && ddr.addr_ready),
        .pop_data  (addr_head),
        .count     (addr_count),
        .empty     (addr_empty)
    );

    // Outputs are forced to zero while their channel is idle.
    assign head_gated = data_empty ? '0 : data_head;

    generate
        for (gi = 0; gi < BATCH; gi++) begin : g_lane
`ifdef PE2DDR_RELU_EN
            assign out_data[gi*DATA_W +: DATA_W] = head_gated[gi*DATA_W + DATA_W - 1]
                                                 ? '0 : head_gated[gi*DATA_W +: DATA_W];
`else
            assign out_data[gi*DATA_W +: DATA_W] = head_gated[gi*DATA_W +: DATA_W];
`endif
        end
    endgenerate

    assign ddr.valid      = !data_empty;
    assign ddr.data       = out_data;
    assign ddr.last       = !data_empty && beat_last;
    assign ddr.addr_valid = !addr_empty;
    assign ddr.addr       = addr_empty ? '0 : addr_head.addr;
    assign ddr.size       = addr_empty ? '0 : addr_head.size;
    assign done           = (state_reg == S_DONE);
endmodule

// File: tb/tb_pe2ddr.sv
// Scoreboard bench for pe2ddr: expected bursts/beats queued at start, checked on handshake.
module tb_pe2ddr;
    import pe2ddr_pkg::*;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic                  done;
    logic [DDR_ADDR_W-1:0] conf_st_addr;
    logic [DDR_ADDR_W-1:0] conf_step;
    logic [BURST_W-1:0]    conf_word_num;
    logic [31:0]           conf_mask;
    logic [7:0]            rbuf_rd_addr;
    logic [31:0]           rbuf_rd_en;
    logic [DDR_W-1:0]      rbuf_rd_data;

    pe2ddr_if ddr_if ();

    pe2ddr dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .done          (done),
        .conf_st_addr  (conf_st_addr),
        .conf_step     (conf_step),
        .conf_word_num (conf_word_num),
        .conf_mask     (conf_mask),
        .rbuf_rd_addr  (rbuf_rd_addr),
        .rbuf_rd_en    (rbuf_rd_en),
        .rbuf_rd_data  (rbuf_rd_data),
        .ddr           (ddr_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int beats_seen = 0;
    bit ready_rand = 1'b0;
    bit hold_pending = 1'b0;
    logic [DDR_W-1:0] hold_data;
    logic hold_last;
    logic [DDR_W:0] exp_beat_q [$];
    logic [DDR_ADDR_W+BURST_W-1:0] exp_addr_q [$];

    // Buffer contents: lane1 is always -3, lane2 always negative, lanes 0/3 positive.
    function automatic logic [63:0] buf_word(input int p, input int a);
        logic [15:0] l0, l1, l2, l3;
        l0 = 16'(p * 256 + a);
        l1 = 16'hFFFD;
        l2 = ~16'(p * 256 + a);
        l3 = 16'(a * 128 + p);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [63:0] exp_word(input logic [63:0] w);
        logic [63:0] r;
        r = w;
`ifdef PE2DDR_RELU_EN
        for (int l = 0; l < 4; l++) if (w[l*16+15]) r[l*16 +: 16] = 16'h0;
`endif
        return r;
    endfunction

    always @(posedge clk) begin
        rbuf_rd_data <= '0;
        for (int p = 0; p < 32; p++)
            if (rbuf_rd_en[p]) rbuf_rd_data <= buf_word(p, int'(rbuf_rd_addr));
    end

    // One cycle: set readies for the coming edge, then consume any handshake.
    task automatic tick();
        logic [DDR_W:0] eb;
        logic [DDR_ADDR_W+BURST_W-1:0] ea;
        @(negedge clk);
        ddr_if.ready      = ready_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
        ddr_if.addr_ready = ready_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
        if (done) done_cnt++;
        if (hold_pending && rst) begin
            total++;
            if (ddr_if.valid !== 1'b1 || ddr_if.data !== hold_data || ddr_if.last !== hold_last) begin
                bad++;
                $display("FAIL hold_stable: got valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                         ddr_if.valid, ddr_if.data, ddr_if.last, hold_data, hold_last);
            end
        end
        hold_pending = ddr_if.valid && !ddr_if.ready;
        hold_data = ddr_if.data;
        hold_last = ddr_if.last;
        if (ddr_if.valid && ddr_if.ready) begin
            beats_seen++;
            total++;
            if (exp_beat_q.size() == 0) begin
                bad++;
                $display("FAIL beat_extra: got data=%h last=%b, required no beat", ddr_if.data, ddr_if.last);
            end else begin
                eb = exp_beat_q.pop_front();
                if ({ddr_if.data, ddr_if.last} !== eb) begin
                    bad++;
                    $display("FAIL beat: got data=%h last=%b, required data=%h last=%b",
                             ddr_if.data, ddr_if.last, eb[DDR_W:1], eb[0]);
                end
            end
        end
        if (ddr_if.addr_valid && ddr_if.addr_ready) begin
            total++;
            if (exp_addr_q.size() == 0) begin
                bad++;
                $display("FAIL addr_extra: got addr=%h size=%0d, required none", ddr_if.addr, ddr_if.size);
            end else begin
                ea = exp_addr_q.pop_front();
                if ({ddr_if.addr, ddr_if.size} !== ea) begin
                    bad++;
                    $display("FAIL addr: got addr=%h size=%0d, required addr=%h size=%0d",
                             ddr_if.addr, ddr_if.size, ea[DDR_ADDR_W+BURST_W-1:BURST_W], ea[BURST_W-1:0]);
                end
            end
        end
        if (rbuf_rd_en != '0) begin
            total++;
            if (!$onehot(rbuf_rd_en)) begin
                bad++;
                $display("FAIL rd_en_onehot: got %h, required one-hot", rbuf_rd_en);
            end
        end
        total++;
        if (int'(dut.data_count) > 4) begin
            bad++;
            $display("FAIL fifo_level: got %0d, required <= 4", dut.data_count);
        end
    endtask

    task automatic start_xfer(input logic [31:0] st, input logic [31:0] step,
                              input logic [7:0] n, input logic [31:0] mask);
        int k;
        int words;
        k = 0;
        words = (n == 0) ? 256 : int'(n);
        for (int p = 0; p < 32; p++) begin
            if (mask[p]) begin
                exp_addr_q.push_back({st + 32'(k) * step, n});
                k++;
                for (int w = 0; w < words; w++)
                    exp_beat_q.push_back({exp_word(buf_word(p, w)), (w == words - 1)});
            end
        end
        conf_st_addr = st;
        conf_step = step;
        conf_word_num = n;
        conf_mask = mask;
        start = 1'b1;
        tick();
        start = 1'b0;
        conf_st_addr = $urandom;
        conf_step = $urandom;
        conf_word_num = 8'($urandom);
        conf_mask = $urandom;
    endtask

    task automatic wait_done(input int budget, output bit got, output int cycles);
        got = 1'b0;
        cycles = 0;
        while (!got && cycles < budget) begin
            tick();
            cycles++;
            if (done) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        total++;
        if ({done, ddr_if.valid, ddr_if.addr_valid, ddr_if.last} !== 4'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got done/valid/addr_valid/last=%b, required 0000",
                     {done, ddr_if.valid, ddr_if.addr_valid, ddr_if.last});
        end
        total++;
        if (rbuf_rd_en !== '0 || rbuf_rd_addr !== '0 || ddr_if.addr !== '0 || ddr_if.data !== '0) begin
            bad++;
            $display("FAIL reset_bus: got rd_en=%h rd_addr=%h addr=%h data=%h, required all 0",
                     rbuf_rd_en, rbuf_rd_addr, ddr_if.addr, ddr_if.data);
        end
        rst = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_empty_mask();
        int done_at;
        bit saw_valid;
        done_cnt = 0;
        done_at = 0;
        saw_valid = 1'b0;
        start_xfer(32'h1000, 32'h40, 8'd4, 32'h0);
        if (done) done_at = 1;
        for (int i = 2; i <= 6; i++) begin
            tick();
            if (done && done_at == 0) done_at = i;
            if (ddr_if.valid || ddr_if.addr_valid) saw_valid = 1'b1;
        end
        total++;
        if (done_at != 3) begin
            bad++;
            $display("FAIL empty_done_latency: got %0d, required 3", done_at);
        end
        total++;
        if (saw_valid || done_cnt != 1) begin
            bad++;
            $display("FAIL empty_quiet: got valid_seen=%b done_cnt=%0d, required 0 and 1", saw_valid, done_cnt);
        end
        $display("test_empty_mask done_at=%0d", done_at);
    endtask

    task automatic run_check(input string name, input logic [31:0] st, input logic [31:0] step,
                             input logic [7:0] n, input logic [31:0] mask,
                             input int budget, input int max_cycles);
        bit got;
        int cycles;
        int beats0;
        done_cnt = 0;
        beats0 = beats_seen;
        start_xfer(st, step, n, mask);
        wait_done(budget, got, cycles);
        repeat (3) tick();
        total++;
        if (!got || cycles + 1 > max_cycles) begin
            bad++;
            $display("FAIL %s_done: got done=%b after %0d cycles, required done within %0d",
                     name, got, cycles + 1, max_cycles);
        end
        total++;
        if (done_cnt != 1 || exp_beat_q.size() != 0 || exp_addr_q.size() != 0) begin
            bad++;
            $display("FAIL %s_complete: got done_cnt=%0d beats_left=%0d addrs_left=%0d, required 1 0 0",
                     name, done_cnt, exp_beat_q.size(), exp_addr_q.size());
        end
        $display("%s: %0d beats, %0d cycles", name, beats_seen - beats0, cycles + 1);
        exp_beat_q.delete();
        exp_addr_q.delete();
    endtask

    task automatic test_single();
        run_check("single", 32'h1000, 32'h40, 8'd4, 32'h1, 200, 200);
    endtask

    task automatic test_multi();
        run_check("multi", 32'h1000, 32'h40, 8'd2, 32'h8000_0005, 200, 200);
    endtask

    task automatic test_random_ready();
        ready_rand = 1'b1;
        run_check("random_ready", 32'hFFFF_FF00, 32'h100, 8'd16, 32'h0010_0402, 3000, 3000);
        ready_rand = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_check("back_to_back", 32'h4000, 32'h80, 8'd16, 32'h3, 200, 45);
    endtask

    task automatic test_full_burst();
        run_check("full_burst", 32'h8000, 32'h0, 8'd0, 32'h8000_0000, 400, 275);
    endtask

    task automatic test_reset_mid();
        int beats0;
        int guard;
        done_cnt = 0;
        beats0 = beats_seen;
        guard = 0;
        start_xfer(32'h3000, 32'h40, 8'd16, 32'h1);
        while (beats_seen - beats0 < 5 && guard < 100) begin
            tick();
            guard++;
        end
        total++;
        if (beats_seen - beats0 != 5) begin
            bad++;
            $display("FAIL mid_reach_beat5: got %0d beats, required 5", beats_seen - beats0);
        end
        rst = 1'b0;
        tick();
        total++;
        if ({done, ddr_if.valid, ddr_if.addr_valid, ddr_if.last} !== 4'b0 || rbuf_rd_en !== '0
            || rbuf_rd_addr !== '0 || ddr_if.data !== '0 || ddr_if.addr !== '0 || ddr_if.size !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got done=%b valid=%b addr_valid=%b last=%b rd_en=%h data=%h addr=%h, required all 0",
                     done, ddr_if.valid, ddr_if.addr_valid, ddr_if.last, rbuf_rd_en, ddr_if.data, ddr_if.addr);
        end
        exp_beat_q.delete();
        exp_addr_q.delete();
        rst = 1'b1;
        tick();
        total++;
        if (done_cnt != 0) begin
            bad++;
            $display("FAIL mid_no_done: got done_cnt=%0d, required 0", done_cnt);
        end
        run_check("after_reset", 32'h2000, 32'h10, 8'd3, 32'h6, 200, 200);
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        conf_st_addr = '0;
        conf_step = '0;
        conf_word_num = '0;
        conf_mask = '0;
        ddr_if.ready = 1'b1;
        ddr_if.addr_ready = 1'b1;
        test_reset();
        test_empty_mask();
        test_single();
        test_multi();
        test_random_ready();
        test_back_to_back();
        test_full_burst();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
